// File: rtl/collatz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_pkg
//  Description : Shared types and constants for the collatz job scheduler.
//                Holds the scheduler state encoding and the width of the
//                RUN-cycle counter / reported iteration count.
//  Revision    : 1.0  initial release
// ============================================================================
package collatz_pkg;

    // Width of the RUN counter and of the reported iteration count.
    localparam int COUNT_W = 16;

    // Scheduler states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage : collatz_pkg
`default_nettype wire

// File: rtl/collatz_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first
//                requesting index strictly after the last-served index,
//                wrapping from NREQ-1 back to 0. The last-served index itself
//                has the lowest priority, so a requester that keeps asking
//                only wins again once nobody else is waiting.
//  Ports       : i_req   [NREQ]  request vector
//                i_last  [IW]    index of the last-served requester
//                o_grant [NREQ]  one-hot grant (all zero when no request)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Walk the indices in priority order last+1, last+2, ... last+NREQ
    // (mod NREQ) and take the first one that is requesting.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/collatz_sched.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_sched
//  Description : Shares one external collatz iterator among NREQ requesters.
//                A round-robin winner is picked in IDLE, its start value is
//                launched to the iterator (cgo/cn) while the requester is
//                acknowledged, the iterator is timed in RUN until cdone or
//                TIMEOUT, and the result is returned with a one-cycle
//                rsp_valid pulse to the same requester.
//  Ports       : clk          clock (rising edge)
//                rst_n        synchronous, active-low reset
//                req    [N]   per-requester job request (level)
//                req_n  [N]x32 per-requester start value
//                ack    [N]   one-hot pulse: start value captured
//                rsp_valid[N] one-hot pulse: result available
//                rsp_count    iteration cycle count (registered, held)
//                rsp_timeout  job aborted at TIMEOUT (registered, held)
//                busy         high whenever not IDLE
//                cgo / cn     go pulse and start value to the iterator
//                cdone        done from the iterator (only looked at in RUN)
//  Revision    : 1.0  initial release
// ============================================================================
module collatz_sched
    import collatz_pkg::*;
#(
    parameter int                  NREQ    = 4,
    parameter logic [COUNT_W-1:0]  TIMEOUT = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0][31:0]    req_n,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [COUNT_W-1:0]       rsp_count,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic                     cgo,
    output logic [31:0]              cn,
    input  logic                     cdone
);

    localparam int            IW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] C_LAST_INIT = IW'(NREQ - 1);

    state_t               r_state;
    logic [NREQ-1:0]      r_gnt_oh;
    logic [IW-1:0]        r_gnt_idx;
    logic [IW-1:0]        r_last;
    logic [COUNT_W-1:0]   r_cnt;
    logic [COUNT_W-1:0]   r_rsp_count;
    logic                 r_rsp_timeout;

    logic [NREQ-1:0]      w_grant;
    logic [IW-1:0]        w_grant_idx;
    logic [COUNT_W-1:0]   w_cnt_inc;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req   (req),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // One-hot grant to index, used for cn selection and last-served update.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = IW'(i);
            end
        end
    end

    // Count value including the current RUN cycle.
    assign w_cnt_inc = r_cnt + COUNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_gnt_oh      <= '0;
            r_gnt_idx     <= '0;
            r_last        <= C_LAST_INIT;
            r_cnt         <= '0;
            r_rsp_count   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt_oh  <= w_grant;
                        r_gnt_idx <= w_grant_idx;
                        r_state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_cnt <= w_cnt_inc;
                    // Completion wins over timeout when both land together.
                    // Leaving RUN at TIMEOUT also keeps the counter from
                    // ever wrapping.
                    if (cdone) begin
                        r_rsp_count   <= w_cnt_inc;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RESP;
                    end else if (w_cnt_inc >= TIMEOUT) begin
                        r_rsp_count   <= TIMEOUT;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    r_last  <= r_gnt_idx;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from the registered state so they are glitch-free
    // and automatically cleared by reset.
    assign busy        = (r_state != IDLE);
    assign cgo         = (r_state == LAUNCH);
    assign ack         = (r_state == LAUNCH) ? r_gnt_oh : '0;
    assign cn          = (r_state == LAUNCH) ? req_n[r_gnt_idx] : 32'd0;
    assign rsp_valid   = (r_state == RESP) ? r_gnt_oh : '0;
    assign rsp_count   = r_rsp_count;
    assign rsp_timeout = r_rsp_timeout;

endmodule : collatz_sched
`default_nettype wire

// File: tb/tb_collatz_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collatz_sched
//  Description : Self-checking bench for collatz_sched with a stub iterator
//                that pulses done exactly L cycles after go. Expected
//                responses are queued when a request is driven and popped
//                when rsp_valid appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_collatz_sched;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req = '0;
    logic [3:0][31:0]  req_n = '0;
    logic [3:0]        ack;
    logic [3:0]        rsp_valid;
    logic [15:0]       rsp_count;
    logic              rsp_timeout;
    logic              busy;
    logic              cgo;
    logic [31:0]       cn;
    logic              cdone;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          idx;
        logic [15:0] cnt;
        logic        to;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    collatz_sched #(
        .NREQ    (4),
        .TIMEOUT (16'd10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_n       (req_n),
        .ack         (ack),
        .rsp_valid   (rsp_valid),
        .rsp_count   (rsp_count),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .cgo         (cgo),
        .cn          (cn),
        .cdone       (cdone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub iterator: done for one cycle exactly stub_l cycles after go.
    // stub_l = 0 means the iterator never finishes.
    int   stub_l   = 0;
    int   rem      = 0;
    logic stale_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n)          rem <= 0;
        else if (cgo)        rem <= stub_l;
        else if (rem != 0)   rem <= rem - 1;
    end

    assign cdone = (rem == 1) || (stale_en && cgo);

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cgo !== 1'b0)        begin errors++; $display("FAIL reset_cgo: got %b want 0", cgo); end
        checks++; if (ack !== 4'b0)        begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (rsp_valid !== 4'b0)  begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_count !== 16'd0) begin errors++; $display("FAIL reset_rsp_count: got %0d want 0", rsp_count); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp_timeout: got %b want 0", rsp_timeout); end
        checks++; if (cn !== 32'd0)        begin errors++; $display("FAIL reset_cn: got %0d want 0", cn); end
    endtask

    task automatic test_single;
        bit   ok;
        int   t;
        exp_t e;
        stub_l   = 5;
        req_n[0] = 32'd7;
        @(negedge clk);
        req = 4'b0001;
        t   = cyc;
        sb.push_back('{idx: 0, cnt: 16'd5, to: 1'b0, cyc: t + 7});
        wait_ack(ok);
        req = '0;
        checks++; if (!ok) begin errors++; $display("FAIL single_ack_wait: no ack seen"); end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
        checks++; if (cyc !== t + 1)   begin errors++; $display("FAIL single_ack_cycle: got %0d want %0d", cyc, t + 1); end
        checks++; if (cgo !== 1'b1 || cn !== 32'd7) begin errors++; $display("FAIL single_launch: cgo=%b cn=%0d want 1/7", cgo, cn); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || cgo !== 1'b0) begin errors++; $display("FAIL single_run: busy=%b cgo=%b want 1/0", busy, cgo); end
        wait_rsp(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++; $display("FAIL single_rsp_wait: no response or empty scoreboard");
        end else begin
            e = sb.pop_front();
            checks++; if (rsp_valid !== (4'b0001 << e.idx)) begin errors++; $display("FAIL single_rsp_valid: got %b want idx %0d", rsp_valid, e.idx); end
            checks++; if (rsp_count !== e.cnt)  begin errors++; $display("FAIL single_rsp_count: got %0d want %0d", rsp_count, e.cnt); end
            checks++; if (rsp_timeout !== e.to) begin errors++; $display("FAIL single_rsp_timeout: got %b want %b", rsp_timeout, e.to); end
            checks++; if (cyc !== e.cyc)        begin errors++; $display("FAIL single_rsp_cycle: got %0d want %0d", cyc, e.cyc); end
        end
        repeat (2) @(negedge clk);
        checks++; if (rsp_count !== 16'd5 || rsp_valid !== 4'b0) begin errors++; $display("FAIL single_hold: count=%0d valid=%b want 5/0000", rsp_count, rsp_valid); end
    endtask

    task automatic test_fairness;
        bit   ok;
        int   t;
        int   prev_ack;
        int   order[5];
        exp_t e;
        order = '{0, 1, 2, 3, 0};
        // Reset so the last-served index returns to 3 and requester 0 leads.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        stub_l = 2;
        for (int i = 0; i < 4; i++) req_n[i] = 32'd100 + 32'(i);
        @(negedge clk);
        req = 4'b1111;
        t   = cyc;
        for (int k = 0; k < 5; k++)
            sb.push_back('{idx: order[k], cnt: 16'd2, to: 1'b0, cyc: t + 4 + 5 * k});
        prev_ack = t - 4;
        for (int k = 0; k < 5; k++) begin
            wait_ack(ok);
            if (k == 4) req = '0;
            checks++; if (!ok) begin errors++; $display("FAIL fair_ack_wait[%0d]: no ack", k); end
            checks++; if (ack !== (4'b0001 << order[k])) begin errors++; $display("FAIL fair_ack[%0d]: got %b want idx %0d", k, ack, order[k]); end
            checks++; if (cn !== 32'd100 + 32'(order[k])) begin errors++; $display("FAIL fair_cn[%0d]: got %0d want %0d", k, cn, 100 + order[k]); end
            checks++; if (cyc - prev_ack !== 5) begin errors++; $display("FAIL fair_spacing[%0d]: got %0d want 5", k, cyc - prev_ack); end
            prev_ack = cyc;
            wait_rsp(ok);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++; $display("FAIL fair_rsp_wait[%0d]: no response or empty scoreboard", k);
            end else begin
                e = sb.pop_front();
                checks++; if (rsp_valid !== (4'b0001 << e.idx)) begin errors++; $display("FAIL fair_rsp_valid[%0d]: got %b want idx %0d", k, rsp_valid, e.idx); end
                checks++; if (rsp_count !== e.cnt || rsp_timeout !== e.to) begin errors++; $display("FAIL fair_rsp_data[%0d]: got %0d/%b want %0d/%b", k, rsp_count, rsp_timeout, e.cnt, e.to); end
                checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL fair_rsp_cycle[%0d]: got %0d want %0d", k, cyc, e.cyc); end
            end
        end
    endtask

    // One job on requester idx, iterator latency l (0 = never done);
    // exp_cnt/exp_to/exp_lat describe the expected response.
    task automatic test_job(input string name, input int idx, input int l, input logic stale,
                            input logic [15:0] exp_cnt, input logic exp_to, input int exp_lat);
        bit   ok;
        int   t;
        exp_t e;
        stub_l     = l;
        stale_en   = stale;
        req_n[idx] = 32'd27 + 32'(idx);
        @(negedge clk);
        req = 4'b0001 << idx;
        t   = cyc;
        sb.push_back('{idx: idx, cnt: exp_cnt, to: exp_to, cyc: t + exp_lat});
        wait_ack(ok);
        req = '0;
        checks++; if (!ok || ack !== (4'b0001 << idx)) begin errors++; $display("FAIL %s_ack: got %b want idx %0d", name, ack, idx); end
        wait_rsp(ok);
        stale_en = 1'b0;
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++; $display("FAIL %s_rsp_wait: no response or empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            checks++; if (rsp_valid !== (4'b0001 << e.idx)) begin errors++; $display("FAIL %s_rsp_valid: got %b want idx %0d", name, rsp_valid, e.idx); end
            checks++; if (rsp_count !== e.cnt)  begin errors++; $display("FAIL %s_rsp_count: got %0d want %0d", name, rsp_count, e.cnt); end
            checks++; if (rsp_timeout !== e.to) begin errors++; $display("FAIL %s_rsp_timeout: got %b want %b", name, rsp_timeout, e.to); end
            checks++; if (cyc !== e.cyc)        begin errors++; $display("FAIL %s_rsp_cycle: got %0d want %0d", name, cyc, e.cyc); end
        end
    endtask

    task automatic test_reset_mid_run;
        bit   ok;
        bit   seen;
        int   t;
        exp_t e;
        stub_l   = 8;
        req_n[0] = 32'd9;
        @(negedge clk);
        req = 4'b0001;
        t   = cyc;
        wait_ack(ok);
        req = '0;
        repeat (3) @(negedge clk);
        checks++; if (cyc !== t + 4 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: cyc=%0d busy=%b want %0d/1", cyc, busy, t + 4); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid != 0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp: got rsp_valid activity want none"); end
        stub_l   = 5;
        req_n[3] = 32'd33;
        req = 4'b1000;
        t   = cyc;
        sb.push_back('{idx: 3, cnt: 16'd5, to: 1'b0, cyc: t + 7});
        wait_ack(ok);
        req = '0;
        checks++; if (!ok || ack !== 4'b1000 || cn !== 32'd33) begin errors++; $display("FAIL rstmid_ack3: ack=%b cn=%0d want 1000/33", ack, cn); end
        wait_rsp(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++; $display("FAIL rstmid_rsp_wait: no response or empty scoreboard");
        end else begin
            e = sb.pop_front();
            checks++; if (rsp_valid !== (4'b0001 << e.idx) || rsp_count !== e.cnt || rsp_timeout !== e.to) begin
                errors++; $display("FAIL rstmid_rsp: valid=%b count=%0d to=%b want idx %0d/%0d/%b", rsp_valid, rsp_count, rsp_timeout, e.idx, e.cnt, e.to);
            end
            checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL rstmid_rsp_cycle: got %0d want %0d", cyc, e.cyc); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        // Last served is 0 after fairness: grant order then 1, 2, 0.
        test_job("timeout",  1, 0,  1'b0, 16'd10, 1'b1, 12);
        test_job("boundary", 2, 10, 1'b0, 16'd10, 1'b0, 12);
        test_job("stale",    0, 3,  1'b1, 16'd3,  1'b0, 5);
        test_reset_mid_run;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule : tb_collatz_sched
`default_nettype wire
